// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction RAM loader.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int   BYTES_PER_WORD = 4;
  localparam logic RAM_WRITE      = 1'b0;
  localparam logic RAM_READ       = 1'b1;

endpackage

// File: rtl/instr_loader_if.sv
// Byte stream in, RAM_i write port and status out. master = loader, slave = host/RAM side.
interface instr_loader_if #(
  parameter int ADDR_W = 16
);
  logic              Start;
  logic [7:0]        Byte_in;
  logic              Byte_valid;
  logic              Byte_ready;
  logic              Enable_i;
  logic              RW_ram_i;
  logic [ADDR_W-1:0] Address_in_i;
  logic [31:0]       In_i;
  logic              Busy;
  logic              Done;
  logic              Error;
  logic [ADDR_W-1:0] Word_count;

  modport master (
    input  Start, Byte_in, Byte_valid,
    output Byte_ready, Enable_i, RW_ram_i, Address_in_i, In_i,
           Busy, Done, Error, Word_count
  );

  modport slave (
    output Start, Byte_in, Byte_valid,
    input  Byte_ready, Enable_i, RW_ram_i, Address_in_i, In_i,
           Busy, Done, Error, Word_count
  );
endinterface

// File: rtl/instr_loader_word_packer.sv
// Packs a big-endian byte stream into 32-bit words; word/word_full are valid in the cycle
// the last byte of a word is shifted in.
module word_packer
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [BYTES_PER_WORD-2:0][7:0] held_q;
  logic [1:0]                     idx_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      held_q <= '0;
      idx_q  <= '0;
    end else if (shift_en) begin
      held_q <= {held_q[BYTES_PER_WORD-3:0], byte_in};
      idx_q  <= idx_q + 2'd1;
    end
  end

  // Oldest byte lands in the MSBs; the word is presented combinationally with the final byte.
  assign word      = {held_q, byte_in};
  assign word_full = shift_en && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_loader.sv
// Boot loader writing a length-prefixed byte stream into RAM_i as 32-bit words.
// Optional trailing checksum byte: define INSTR_LOADER_CHECKSUM_EN.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256
) (
  input logic            Clk,
  input logic            Reset,
  instr_loader_if.master bus
);

  state_t            state_q, state_d;
  logic [7:0]        len_hi_q;
  logic [15:0]       len_q;
  logic [ADDR_W-1:0] wc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;

  logic        xfer;
  logic        start_ok;
  logic        shift_en;
  logic        word_full;
  logic        last_word;
  logic [31:0] pack_word;
  logic [15:0] len_rx;

  assign xfer      = bus.Byte_valid && bus.Byte_ready;
  assign start_ok  = bus.Start && (state_q inside {IDLE, DONE, ERR});
  assign shift_en  = (state_q == DATA) && xfer;
  assign len_rx    = {len_hi_q, bus.Byte_in};
  assign last_word = (wc_q == ADDR_W'(len_q));

`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam state_t TAIL = CSUM;
  logic [7:0] csum_q;

  always_ff @(posedge Clk) begin
    if (Reset || start_ok) csum_q <= '0;
    else if (shift_en)     csum_q <= csum_q + bus.Byte_in;
  end
`else
  localparam state_t TAIL = DONE;
`endif

  word_packer u_packer (
    .clk       (Clk),
    .rst       (Reset),
    .clr       (start_ok),
    .shift_en  (shift_en),
    .byte_in   (bus.Byte_in),
    .word      (pack_word),
    .word_full (word_full)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: if (bus.Start) state_d = LEN_HI;
      LEN_HI:          if (xfer) state_d = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          // Length is range-checked before any write, so the address can never wrap.
          if (len_rx == 16'd0)                 state_d = TAIL;
          else if (32'(len_rx) > 32'(DEPTH))   state_d = ERR;
          else                                 state_d = DATA;
        end
      end
      DATA:            if (word_full) state_d = WRITE;
      WRITE:           state_d = last_word ? TAIL : DATA;
`ifdef INSTR_LOADER_CHECKSUM_EN
      CSUM:            if (xfer) state_d = (bus.Byte_in == csum_q) ? DONE : ERR;
`endif
      default:         state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      len_hi_q <= '0;
      len_q    <= '0;
      wc_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) wc_q <= '0;
      if (state_q == LEN_HI && xfer) len_hi_q <= bus.Byte_in;
      if (state_q == LEN_LO && xfer) len_q    <= len_rx;
      // Address/data are captured with the 4th byte so the WRITE cycle presents them registered.
      if (word_full) begin
        addr_q <= wc_q;
        data_q <= pack_word;
        wc_q   <= wc_q + ADDR_W'(1);
      end
    end
  end

  assign bus.Byte_ready   = state_q inside {LEN_HI, LEN_LO, DATA, CSUM};
  assign bus.Busy         = !(state_q inside {IDLE, DONE, ERR});
  assign bus.Done         = (state_q == DONE);
  assign bus.Error        = (state_q == ERR);
  assign bus.Enable_i     = (state_q == WRITE);
  assign bus.RW_ram_i     = (state_q == WRITE) ? RAM_WRITE : RAM_READ;
  assign bus.Address_in_i = addr_q;
  assign bus.In_i         = data_q;
  assign bus.Word_count   = wc_q;

endmodule

// File: tb/tb_instr_loader.sv
// Randomized self-checking bench for instr_loader with a frame-level reference model.
module tb_instr_loader;
  import instr_loader_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 256;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  instr_loader_if #(.ADDR_W(ADDR_W)) bus();

  instr_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  logic [7:0]  pl[$];
  logic [31:0] mem     [DEPTH];
  bit          written [DEPTH];
  logic [31:0] img     [3];
  int          en_cnt;
  int          exp_wc;
  bit          rst_q;
  bit          mon_en;
  wr_t         mw;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge Clk) rst_q <= Reset;

  // Per-cycle compare against the frame model's expected write list.
  always @(negedge Clk) begin
    if (mon_en) begin
      if (rst_q) begin
        chk("rst_ready",  bus.Byte_ready,   0);
        chk("rst_enable", bus.Enable_i,     0);
        chk("rst_rw",     bus.RW_ram_i,     1);
        chk("rst_addr",   bus.Address_in_i, 0);
        chk("rst_data",   bus.In_i,         0);
        chk("rst_busy",   bus.Busy,         0);
        chk("rst_done",   bus.Done,         0);
        chk("rst_error",  bus.Error,        0);
        chk("rst_wc",     bus.Word_count,   0);
        exp_q.delete();
        exp_wc = 0;
      end else begin
        chk("rw_vs_enable", bus.RW_ram_i, !bus.Enable_i);
        chk("done_error_excl", bus.Done && bus.Error, 0);
        if (bus.Done || bus.Error) begin
          chk("ready_when_finished", bus.Byte_ready, 0);
          chk("busy_when_finished", bus.Busy, 0);
        end
        if (bus.Enable_i) begin
          en_cnt++;
          exp_wc++;
          if (bus.Address_in_i < DEPTH) begin
            mem[bus.Address_in_i]     = bus.In_i;
            written[bus.Address_in_i] = 1'b1;
          end
          chk("write_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            mw = exp_q.pop_front();
            chk("write_addr", bus.Address_in_i, mw.addr);
            chk("write_data", bus.In_i, mw.data);
          end
        end
        chk("word_count", bus.Word_count, exp_wc);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    for (int n = 0; n < 300; n++) begin
      bus.Byte_in    = b;
      bus.Byte_valid = ($urandom_range(99) >= gap);
      @(negedge Clk);
      acc = bus.Byte_valid && bus.Byte_ready;
      @(posedge Clk); #1;
      if (acc) break;
    end
    bus.Byte_valid = 1'b0;
    bus.Byte_in    = $urandom_range(255);
    chk("byte_accepted", acc, 1);
  endtask

  task automatic pulse_start(input bit fresh);
    bus.Start = 1'b1;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    if (fresh) exp_wc = 0;
  endtask

  // One frame of n words taken from pl; the model derives writes and final status from the frame rules.
  task automatic run_frame(input int n, input int gap, input bit bad_csum, input bit busy_start);
    logic [15:0] len;
    logic [7:0]  sum;
    bit          exp_err;
    int          nw;
    bit          fin;
    len     = n[15:0];
    exp_err = (n > DEPTH);
    nw      = exp_err ? 0 : n;
    sum     = 8'd0;
    for (int i = 0; i < nw * 4; i++) sum = sum + pl[i];
    for (int w = 0; w < nw; w++)
      exp_q.push_back('{addr: ADDR_W'(w),
                        data: {pl[4*w], pl[4*w+1], pl[4*w+2], pl[4*w+3]}});
`ifdef INSTR_LOADER_CHECKSUM_EN
    if (!exp_err && bad_csum) exp_err = 1'b1;
`endif
    for (int i = 0; i < DEPTH; i++) written[i] = 1'b0;
    en_cnt = 0;
    pulse_start(1'b1);
    send_byte(len[15:8], gap);
    send_byte(len[7:0], gap);
    if (n > DEPTH) begin
      @(negedge Clk);
      chk("len_reject_error", bus.Error, 1);
      chk("len_reject_ready", bus.Byte_ready, 0);
    end else begin
`ifndef INSTR_LOADER_CHECKSUM_EN
      if (n == 0) begin
        @(negedge Clk);
        chk("zero_len_done_next_cycle", bus.Done, 1);
      end
`endif
      for (int i = 0; i < nw * 4; i++) begin
        send_byte(pl[i], gap);
        if (i == 0 && busy_start) pulse_start(1'b0);
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      send_byte(bad_csum ? sum + 8'd1 : sum, gap);
`endif
    end
    fin = 1'b0;
    for (int c = 0; c < 50 && !fin; c++) begin
      @(negedge Clk);
      fin = bus.Done || bus.Error;
    end
    chk("frame_finished", fin, 1);
    chk("final_done",  bus.Done,  !exp_err);
    chk("final_error", bus.Error, exp_err);
    chk("pending_writes", exp_q.size(), 0);
    chk("enable_pulses", en_cnt, nw);
    chk("final_word_count", bus.Word_count, nw);
    @(posedge Clk); #1;
  endtask

  task automatic fill_random(input int nbytes);
    pl.delete();
    for (int i = 0; i < nbytes; i++) pl.push_back(8'($urandom_range(255)));
  endtask

  initial begin
    bus.Start      = 1'b0;
    bus.Byte_in    = 8'd0;
    bus.Byte_valid = 1'b0;
    mon_en         = 1'b0;
    exp_wc         = 0;
    en_cnt         = 0;
    Reset          = 1'b1;
    repeat (2) @(posedge Clk);
    #1 mon_en = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;

    // Two-word image with hand-known contents.
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_frame(2, 0, 1'b0, 1'b0);
    chk("t1_mem0", mem[0], 32'h11223344);
    chk("t1_mem1", mem[1], 32'hAABBCCDD);
    chk("t1_enables", en_cnt, 2);
    chk("t1_wc", bus.Word_count, 2);

    // Empty program and oversize length.
    pl.delete();
    run_frame(0, 0, 1'b0, 1'b0);
    run_frame(257, 0, 1'b0, 1'b0);
    chk("t3_no_write", written[0], 0);
    repeat (3) @(posedge Clk);
    #1 chk("t3_ready_stays_low", bus.Byte_ready, 0);

    // Same 3-word image with and without valid gaps.
    fill_random(12);
    run_frame(3, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) img[i] = mem[i];
    run_frame(3, 60, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) chk("t4_same_image", mem[i], img[i]);

    // Randomized frames, including a full DEPTH image.
    for (int r = 0; r < 6; r++) begin
      fill_random(24);
      run_frame($urandom_range(1, 6), $urandom_range(0, 70), 1'b0, 1'($urandom_range(1)));
    end
    fill_random(DEPTH * 4);
    run_frame(DEPTH, 0, 1'b0, 1'b0);

`ifdef INSTR_LOADER_CHECKSUM_EN
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(1, 0, 1'b0, 1'b0);
    chk("t6_good_done", bus.Done, 1);
    run_frame(1, 0, 1'b1, 1'b0);
    chk("t6_bad_error", bus.Error, 1);
    chk("t6_word_written", mem[0], 32'h01020304);
`endif

    // Reset part-way through the second word.
    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    for (int i = 0; i < DEPTH; i++) written[i] = 1'b0;
    exp_q.push_back('{addr: 0, data: 32'hDEADBEEF});
    exp_q.push_back('{addr: 1, data: 32'h12345678});
    pulse_start(1'b1);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int i = 0; i < 6; i++) send_byte(pl[i], 0);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    chk("t5_word0_written", mem[0], 32'hDEADBEEF);
    chk("t5_no_write_addr1", written[1], 0);
    chk("t5_idle_not_busy", bus.Busy, 0);
    chk("t5_wc_cleared", bus.Word_count, 0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
